// File: rtl/gcd_32_if.sv
// gcd_32_if: start/done handshake bundle for the gcd_32 engine.
//   start, a_in, b_in : request and operand pair (master -> slave)
//   busy, done, gcd_out : status and result (slave -> master)
//   cycles : run-cycle count of the last computation, only with GCD_CYCLE_CNT_EN
interface gcd_32_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd_out;
`ifdef GCD_CYCLE_CNT_EN
    logic [WIDTH-1:0] cycles;
    modport master (output start, a_in, b_in, input busy, done, gcd_out, cycles);
    modport slave  (input start, a_in, b_in, output busy, done, gcd_out, cycles);
`else
    modport master (output start, a_in, b_in, input busy, done, gcd_out);
    modport slave  (input start, a_in, b_in, output busy, done, gcd_out);
`endif
endinterface

// File: rtl/gcd_32.sv
// gcd_32: iterative subtraction GCD engine driving a 32-bit ripple subtractor.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : gcd_32_if slave (start/a_in/b_in in, busy/done/gcd_out out)
//   GCD_CYCLE_CNT_EN : when defined, adds a saturating run counter on bus.cycles
module subt_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] op
);
    logic [31:0] bw;
    assign bw[0] = 1'b0;
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign op[i] = A[i] ^ B[i] ^ bw[i];
        if (i < 31) begin : g_bw
            assign bw[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bw[i]);
        end
    end
endmodule

module gcd_32 #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    gcd_32_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] ra, rb, gout, mx, mn, op;
    logic             gt, fin;

    // Larger operand is always the minuend so the difference never wraps.
    assign gt  = ra > rb;
    assign mx  = gt ? ra : rb;
    assign mn  = gt ? rb : ra;
    assign fin = (ra == '0) || (rb == '0) || (ra == rb);

    subt_32 u_sub (.A(mx), .B(mn), .op(op));

    assign bus.busy    = state == RUN;
    assign bus.done    = state == DONE;
    assign bus.gcd_out = gout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            gout  <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                ra    <= bus.a_in;
                rb    <= bus.b_in;
                state <= RUN;
            end
        end else if (state == RUN) begin
            if (fin) begin
                gout  <= ra | rb;
                state <= DONE;
            end else if (gt) begin
                ra <= op;
            end else begin
                rb <= op;
            end
        end else begin
            state <= IDLE;
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [WIDTH-1:0] cnt, cnt_inc, cyc;
    assign cnt_inc    = &cnt ? cnt : cnt + 1'b1;
    assign bus.cycles = cyc;

    // The terminating RUN cycle is counted too, so the copy takes the incremented value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            cyc <= '0;
        end else if (state == IDLE && bus.start) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt_inc;
            if (fin) cyc <= cnt_inc;
        end
    end
`endif
endmodule

// File: tb/tb_gcd_32.sv
module tb_gcd_32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcd_32_if #(.WIDTH(32)) bus ();
    gcd_32 #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    longint k = 0;
    longint e0 = 0;
    longint m_n = 0;
    logic [31:0] m_g = 0;
    logic [31:0] gout = 0;
    logic [31:0] cyc = 0;
    bit active = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, k);
        end
    endtask

    // Euclid by division: the subtraction count is the sum of quotients,
    // less one because the engine stops as soon as the operands are equal.
    task automatic ref_gcd(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] g, output longint n);
        longint unsigned x, y, r;
        if (a == 0 || b == 0) begin
            g = a | b;
            n = 0;
        end else begin
            x = a; y = b; n = 0;
            while (y != 0) begin
                n += longint'(x / y);
                r = x % y;
                x = y;
                y = r;
            end
            g = x[31:0];
            n -= 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active = 0;
            gout = 0;
            cyc = 0;
        end else begin
            k++;
            if (active && k == e0 + m_n + 1) begin
                gout = m_g;
                cyc = m_n + 1;
            end
            if (bus.start && (!active || k - 1 >= e0 + m_n + 2)) begin
                active = 1;
                e0 = k;
                ref_gcd(bus.a_in, bus.b_in, m_g, m_n);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(bus.busy), 32'(active && k >= e0 && k <= e0 + m_n));
            chk("done", 32'(bus.done), 32'(active && k == e0 + m_n + 1));
            chk("gcd_out", bus.gcd_out, gout);
`ifdef GCD_CYCLE_CNT_EN
            chk("cycles", bus.cycles, cyc);
`endif
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (active && k < e0 + m_n + 2) begin
            @(negedge clk);
            t++;
            if (t > 5000) begin
                chk("idle_timeout", 32'(t), 32'd0);
                break;
            end
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in = a;
        bus.b_in = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_expect(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g);
        run(a, b);
        wait_idle();
        chk($sformatf("gcd(%0d,%0d)", a, b), bus.gcd_out, g);
    endtask

    initial begin
        logic [31:0] g;
        longint n;
        bus.start = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;

        ref_gcd(12, 8, g, n);
        chk("model_12_8_g", g, 4);
        chk("model_12_8_n", 32'(n), 2);
        ref_gcd(478, 219, g, n);
        chk("model_478_219_g", g, 1);
        chk("model_478_219_n", 32'(n), 19);
        ref_gcd(0, 0, g, n);
        chk("model_0_0_g", g, 0);

        #1 chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_gcd", bus.gcd_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(12, 8);
        chk("trace_ra0", dut.ra, 12);
        chk("trace_rb0", dut.rb, 8);
        @(posedge clk); #1 chk("trace_ra1", dut.ra, 4);
        @(posedge clk); #1 chk("trace_rb2", dut.rb, 4);
        @(posedge clk); #1 chk("trace_done", 32'(bus.done), 1);
        chk("trace_gcd", bus.gcd_out, 4);
`ifdef GCD_CYCLE_CNT_EN
        chk("trace_cycles", bus.cycles, 3);
`endif
        wait_idle();

        run_expect(0, 68, 68);
        run_expect(9, 0, 9);
        run_expect(0, 0, 0);
        run_expect(219, 219, 219);
        run_expect(478, 219, 1);
        run_expect(9, 68, 1);
        run_expect(4, 5, 1);

        // start while busy and while done must both be ignored
        run(12, 8);
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 100; bus.b_in = 75;
        @(negedge clk);
        bus.start = 1'b0;
        while (k < e0 + m_n + 1) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        chk("ignore_gcd", bus.gcd_out, 4);

        // asynchronous abort mid-run
        run(12, 8);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_gcd", bus.gcd_out, 0);
        @(negedge clk);
        rst = 1'b0;
        run_expect(6, 9, 3);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = (i % 7 == 0) ? 32'd0 : 32'($urandom_range(1, 300));
            b = (i % 11 == 0) ? a : 32'($urandom_range(0, 300));
            run(a, b);
            if (i % 3 == 0) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.a_in = $urandom;
                bus.b_in = $urandom;
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/gcd_32.md
# gcd_32

Iterative subtraction-based greatest-common-divisor engine. It sits directly upstream of the 32-bit ripple subtractor `subt_32` and drives that subtractor's `A`/`B` inputs every cycle. It consumes the subtractor's `op` result to update its operand registers until the two operands converge. A start/done handshake loads a new operand pair and returns the GCD.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Must equal the `subt_32` width, so 32 is the only supported value.

Ports:
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request a new computation. Sampled only in IDLE.
- `a_in` input, WIDTH bits: operand A, unsigned. Captured on an accepted `start`.
- `b_in` input, WIDTH bits: operand B, unsigned. Captured on an accepted `start`.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle pulse marking `gcd_out` as freshly valid.
- `gcd_out` output, WIDTH bits: result. Holds its value until the next result is written.
- `cycles` output, WIDTH bits: number of RUN cycles of the last computation. Present only with `GCD_CYCLE_CNT_EN`.

## Operation
- Internal registers:
  - `ra`, `rb`: WIDTH-bit operand registers.
  - `state`: one of IDLE, RUN, DONE.
- One `subt_32` instance.
  - Its `A` port is `max(ra,rb)` and its `B` port is `min(ra,rb)`, using an unsigned compare.
  - Its `op` output is therefore always non-negative and less than `max`.
  - The signed interpretation of `subt_32` is irrelevant, because the operands never cross bit 31 as a signed borrow.
- IDLE:
  - If `start`=1: `ra`<=`a_in`, `rb`<=`b_in`, go to RUN.
  - Otherwise hold.
- RUN, evaluated each cycle in this priority order:
  - If `ra`==0, `rb`==0, or `ra`==`rb`: `gcd_out`<=`ra | rb`, go to DONE. This gives gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0, and gcd(x,x)=x.
  - Else if `ra`>`rb`: `ra`<=`op`.
  - Else: `rb`<=`op`.
- DONE:
  - `done` is high for exactly this one cycle.
  - Next state is IDLE unconditionally. A `start` asserted in DONE is ignored.
- `start` while in RUN or DONE is ignored. There is no queuing, and `a_in`/`b_in` are not sampled.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow is impossible, because the subtrahend is always ≤ the minuend.

## Timing
- Reset values:
  - `state`=IDLE
  - `ra`=`rb`=0
  - `busy`=0
  - `done`=0
  - `gcd_out`=0
  - `cycles`=0
- Reset asserted mid-computation aborts immediately, asynchronously, to the reset values. No `done` is produced.
- `busy` and `done` decode directly from registered state, with no combinational path from `start`.
- Let E0 be the edge that samples `start`=1 in IDLE, and N the number of subtraction steps.
  - `busy` is high from after E0 through the terminating RUN edge, i.e. for N+1 cycles.
  - `done` and the new `gcd_out` are visible after edge E0+N+1 and stay visible for one cycle.
  - The engine is back in IDLE after E0+N+2. The earliest next accepted `start` is on that edge's following edge.
- Zero operand or equal operands: N=0, so `done` is visible after E0+1.
- Worst case: N is about 2^32 for gcd(1, 2^32−1). No timeout is provided.
- The critical path is compare → operand mux → `subt_32` ripple → `ra`/`rb` D input. This path must close in one cycle.

## Configuration
- `GCD_CYCLE_CNT_EN` defined:
  - Adds the `cycles` port and a WIDTH-bit run counter.
  - The counter clears on an accepted `start` and increments on every RUN cycle.
  - It is copied to `cycles` at the same edge `gcd_out` is written, so `cycles`=N+1.
  - It saturates at all-ones.
- `GCD_CYCLE_CNT_EN` undefined: no `cycles` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset: assert `rst` asynchronously between edges. Required: all outputs 0 immediately, and state IDLE.
- `a_in`=12, `b_in`=8, `start` pulse. Required:
  - After E0: `ra`=12, `rb`=8.
  - After E0+1: `ra`=4.
  - After E0+2: `rb`=4.
  - After E0+3: `done`=1 for one cycle, `gcd_out`=4.
  - With the macro: `cycles`=3.
- Zero and equal operands:
  - (0,68) gives `gcd_out`=68.
  - (9,0) gives 9.
  - (0,0) gives 0.
  - (219,219) gives 219.
  - Each has `done` after E0+1.
- (478,219) gives `gcd_out`=1 with N=19, so `done` after E0+20. Then (9,68) gives 1. Then (4,5) gives 1. `gcd_out` holds between runs.
- Ignore rule: `start` with (100,75) while busy computing (12,8). Required: result 4, and (100,75) is never loaded.
- Mid-run reset: assert `rst` after E0+1 of (12,8), release, then start (6,9). Required: no `done` for the aborted run, and `gcd_out`=3 for the new one.
